compare_iter_nb: RTL and testbench
==================================

Name: compare_iter_Nb

Overview:
- Multi-cycle, parametrised integer comparator for the ALU/branch unit of riscv-jedro-1.
- Evaluates all six RV32I comparison relations: EQ, NE, LT, GE, LTU, GEU.
- Scans operands MSB-first, CHUNK bits per cycle, and terminates early on the first differing chunk.
- Uses valid/ready handshakes on input and output so it can sit between pipeline stages or behind a branch-resolution FSM.

Parameters:
- N, 32: operand width in bits; must be a multiple of CHUNK, N >= 2.
- CHUNK, 8: bits compared per cycle; 1 <= CHUNK <= N.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operands and op present.
- in_ready  output  1  block can accept a request.
- a  input  N  left operand.
- b  input  N  right operand.
- op  input  3  funct3 encoding: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 are illegal.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- r  output  1  comparison result.
- illegal  output  1  op was 010/011; r forced to 0.
- busy  output  1  high in CMP or DONE.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, r=0, illegal=0, busy=0, internal index=0. Reset takes effect immediately and mid-operation, discarding any in-flight request.
- States: IDLE, CMP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture a, b and op.
  - For signed ops (LT/GE), invert bit N-1 of both captured operands. Signed compare then reduces to unsigned compare.
  - Set idx to the MSB chunk (N/CHUNK-1) and go to CMP.
  - Illegal op: skip CMP, go directly to DONE with illegal=1, r=0.
- CMP:
  - in_ready=0.
  - Each cycle compare chunk idx of the captured operands as unsigned values.
  - If the chunks differ: record lt = (chunk_a < chunk_b), eq=0, go to DONE.
  - Else if idx==0: record eq=1, lt=0, go to DONE.
  - Else decrement idx.
- DONE:
  - out_valid=1. r and illegal are stable while out_valid=1 and out_ready=0.
  - r is: EQ=eq, NE=~eq, LT/LTU=lt, GE/GEU=~lt.
  - On out_ready, go to IDLE next cycle; out_valid drops.
  - No new request is accepted in the same cycle as the result handshake.
- Latency: accept edge -> out_valid high = k+1 edges, where k = number of chunks examined (1..N/CHUNK).
  - Worst case is N/CHUNK+1.
  - Illegal op: out_valid high after 1 edge.
- Throughput: one request per (k+2) cycles minimum.
- Boundaries:
  - CHUNK=N gives a fixed 2-edge latency.
  - Operand changes after the accept edge are ignored.
  - out_ready held high in advance still yields out_valid for exactly one cycle.
  - in_valid held high while busy is ignored until return to IDLE.

Test Plan (N=32, CHUNK=8):
- LT, a=0xFFFFFFFF, b=0x00000001 -> r=1, out_valid 2 edges after accept. The MSB chunk differs after the sign flip: 0x7F vs 0x80.
- LTU, same operands -> r=0, out_valid 2 edges after accept.
- EQ, a=b=0x12345678 -> r=1 after 5 edges. NE with the same operands -> r=0 after 5 edges.
- GEU, a=0x00000010, b=0x00000011 -> r=0 after 5 edges. GE, a=0x80000000, b=0x7FFFFFFF -> r=0 after 2 edges.
- op=010 with any operands -> illegal=1, r=0 after 1 edge. The next legal request has illegal=0.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles: r, out_valid and illegal stay stable and in_ready=0. Releasing out_ready returns the block to IDLE.
  - Assert rst during CMP: out_valid=0, in_ready=1 and busy=0 immediately, with no result emitted.

Source files
------------

// File: rtl/compare_iter_nb.sv
// Multi-cycle RV32I comparator: scans operands MSB-first, CHUNK bits per cycle,
// and stops at the first differing chunk. Valid/ready handshakes on both sides.
module compare_iter_nb #(
  parameter int unsigned N     = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [2:0]   op_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         r_o,
  output logic         illegal_o,
  output logic         busy_o
);

  localparam int unsigned NumChunks = N / CHUNK;
  localparam int unsigned IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  if ((N % CHUNK) != 0 || N < 2 || CHUNK < 1 || CHUNK > N) begin : g_param_check
    $error("compare_iter_nb: N must be a multiple of CHUNK, N >= 2, 1 <= CHUNK <= N");
  end

  localparam logic [2:0] OpEq  = 3'b000;
  localparam logic [2:0] OpNe  = 3'b001;
  localparam logic [2:0] OpLt  = 3'b100;
  localparam logic [2:0] OpGe  = 3'b101;
  localparam logic [2:0] OpLtu = 3'b110;
  localparam logic [2:0] OpGeu = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StCmp,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      a_q, a_d;
  logic [N-1:0]      b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              r_q, r_d;
  logic              illegal_q, illegal_d;

  logic [N-1:0]      a_sh, b_sh;
  logic [CHUNK-1:0]  chunk_a, chunk_b;
  logic              chunk_ne, chunk_lt;

  // Bring the chunk under inspection down to the bottom bits.
  assign a_sh     = a_q >> (CHUNK * int'(idx_q));
  assign b_sh     = b_q >> (CHUNK * int'(idx_q));
  assign chunk_a  = a_sh[CHUNK-1:0];
  assign chunk_b  = b_sh[CHUNK-1:0];
  assign chunk_ne = (chunk_a != chunk_b);
  assign chunk_lt = (chunk_a < chunk_b);

  function automatic logic eval_r(input logic [2:0] op, input logic eq, input logic lt);
    logic res;
    res = 1'b0;
    unique case (op)
      OpEq:         res = eq;
      OpNe:         res = ~eq;
      OpLt, OpLtu:  res = lt;
      OpGe, OpGeu:  res = ~lt;
      default:      res = 1'b0;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    idx_d     = idx_q;
    r_d       = r_q;
    illegal_d = illegal_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          op_d      = op_i;
          r_d       = 1'b0;
          illegal_d = 1'b0;
          if (op_i[2:1] == 2'b01) begin
            illegal_d = 1'b1;
            state_d   = StDone;
          end else begin
            a_d   = a_i;
            b_d   = b_i;
            // Biasing the sign bit turns a signed compare into an unsigned one.
            if (op_i[2:1] == 2'b10) begin
              a_d[N-1] = ~a_i[N-1];
              b_d[N-1] = ~b_i[N-1];
            end
            idx_d   = IdxW'(NumChunks - 1);
            state_d = StCmp;
          end
        end
      end

      StCmp: begin
        if (chunk_ne) begin
          r_d     = eval_r(op_q, 1'b0, chunk_lt);
          state_d = StDone;
        end else if (idx_q == '0) begin
          r_d     = eval_r(op_q, 1'b1, 1'b0);
          state_d = StDone;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end

      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      idx_q     <= '0;
      r_q       <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      r_q       <= r_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign r_o         = r_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_compare_iter_nb.sv
// Self-checking bench for compare_iter_nb (N=32, CHUNK=8): vector table plus
// hand-written backpressure, held-ready and mid-operation reset sequences.
module tb_compare_iter_nb;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic        r;
  logic        illegal;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_r;
    logic        exp_ill;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic r;
    logic ill;
    int   lat;
  } sb_t;

  sb_t sb_q[$];

  compare_iter_nb #(.N(32), .CHUNK(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .op_i       (op),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .r_o        (r),
    .illegal_o  (illegal),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, push expectation, wait for out_valid, pop and compare.
  task automatic run_req(input string name, input logic [2:0] o, input logic [31:0] va,
                         input logic [31:0] vb, input logic er, input logic ei,
                         input int elat, input bit release_out);
    sb_t exp;
    int  edges;
    chk({name, " in_ready before"}, 32'(in_ready), 32'd1);
    op       = o;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    tick();
    sb_q.push_back('{r: er, ill: ei, lat: elat});
    in_valid = 1'b0;
    // Operands changing after the accept edge must not matter.
    a        = $urandom;
    b        = $urandom;
    op       = 3'($urandom_range(0, 7));
    edges    = 1;
    while (!out_valid && edges < 40) begin
      tick();
      edges++;
    end
    if (!out_valid) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: no out_valid after %0d edges, expected 1", name, edges);
      void'(sb_q.pop_front());
      return;
    end
    if (sb_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: unexpected output r=%0d, expected no output", name, r);
      return;
    end
    exp = sb_q.pop_front();
    chk({name, " r"}, 32'(r), 32'(exp.r));
    chk({name, " illegal"}, 32'(illegal), 32'(exp.ill));
    chk({name, " latency"}, 32'(edges), 32'(exp.lat));
    chk({name, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    if (release_out) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({name, " out_valid drop"}, 32'(out_valid), 32'd0);
    end
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 2};
    vecs[1]  = '{3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 2};
    vecs[2]  = '{3'b000, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 5};
    vecs[3]  = '{3'b001, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 5};
    vecs[4]  = '{3'b111, 32'h0000_0010, 32'h0000_0011, 1'b0, 1'b0, 5};
    vecs[5]  = '{3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 2};
    vecs[6]  = '{3'b010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b1, 1};
    vecs[7]  = '{3'b011, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 1};
    vecs[8]  = '{3'b100, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 5};
    vecs[9]  = '{3'b101, 32'h0000_1234, 32'h0000_1200, 1'b1, 1'b0, 5};
    vecs[10] = '{3'b110, 32'h0001_0000, 32'h0002_0000, 1'b1, 1'b0, 3};
    vecs[11] = '{3'b000, 32'h1234_5678, 32'h1234_5679, 1'b0, 1'b0, 5};
    vecs[12] = '{3'b001, 32'hAB00_0000, 32'hAC00_0000, 1'b1, 1'b0, 2};
    vecs[13] = '{3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 5};
    vecs[14] = '{3'b100, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 2};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    tick();
    tick();
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset r", 32'(r), 32'd0);
    chk("reset illegal", 32'(illegal), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_r,
              vecs[i].exp_ill, vecs[i].exp_lat, 1'b1);
      tick();
    end

    // Backpressure: result held for 5 cycles; in_valid while busy is ignored.
    run_req("bp", 3'b110, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 5, 1'b0);
    in_valid = 1'b1;
    op       = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp hold%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp hold%0d r", i), 32'(r), 32'd1);
      chk($sformatf("bp hold%0d illegal", i), 32'(illegal), 32'd0);
      chk($sformatf("bp hold%0d in_ready", i), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    chk("bp release busy", 32'(busy), 32'd0);

    // out_ready held high in advance: out_valid lasts exactly one cycle.
    out_ready = 1'b1;
    run_req("ordy", 3'b001, 32'h0000_0000, 32'h0100_0000, 1'b1, 1'b0, 2, 1'b0);
    tick();
    chk("ordy single-cycle out_valid", 32'(out_valid), 32'd0);
    chk("ordy back to idle", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    tick();

    // Reset during CMP: discard the in-flight request immediately.
    op       = 3'b000;
    a        = 32'h5555_5555;
    b        = 32'h5555_5555;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rst pre busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst async out_valid", 32'(out_valid), 32'd0);
    chk("rst async in_ready", 32'(in_ready), 32'd1);
    chk("rst async busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (out_valid) seen++;
      end
      chk("rst no result emitted", 32'(seen), 32'd0);
    end
    chk("scoreboard empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
